// File: rtl/mem_arbiter.sv
// Two-requester block memory arbiter: an instruction-fetch side and a data side
// share one memory port. Accesses are 16-byte blocks, serviced one at a time.
//
// state  | meaning
// IDLE   | no access outstanding; sample i_req/d_req and arbitrate
// I_BUSY | instruction-side read issued, waiting for mem_valid
// D_BUSY | data-side read or write-back issued, waiting for mem_valid
// I_RESP | i_ack pulse cycle
// D_RESP | d_ack pulse cycle
module mem_arbiter #(
  parameter int DATA_PRIORITY = 0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_req,
  input  logic [31:0]  i_addr,
  output logic         i_ack,
  output logic [127:0] i_data,
  input  logic         d_req,
  input  logic         d_write,
  input  logic [31:0]  d_addr,
  input  logic [127:0] d_wdata,
  output logic         d_ack,
  output logic [127:0] d_data,
  output logic         mem_enable,
  output logic         mem_write,
  output logic [31:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_valid,
  output logic         busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_BUSY = 3'd1,
    D_BUSY = 3'd2,
    I_RESP = 3'd3,
    D_RESP = 3'd4
  } state_t;

  state_t state;
  logic   last_grant;  // 1 = data side won the previous arbitration
  logic   grant_d;

  // On a tie, the data side wins when prioritised or when I was served last.
  always_comb begin
    grant_d = d_req && (!i_req || (DATA_PRIORITY != 0) || !last_grant);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      mem_enable <= 1'b0;
      mem_write  <= 1'b0;
      busy       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_data     <= '0;
      d_data     <= '0;
      last_grant <= 1'b1;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_req || d_req) begin
            mem_enable <= 1'b1;
            busy       <= 1'b1;
            if (grant_d) begin
              mem_addr   <= {d_addr[31:4], 4'b0000};
              mem_write  <= d_write;
              mem_wdata  <= d_wdata;
              last_grant <= 1'b1;
              state      <= D_BUSY;
            end else begin
              mem_addr   <= {i_addr[31:4], 4'b0000};
              mem_write  <= 1'b0;
              last_grant <= 1'b0;
              state      <= I_BUSY;
            end
          end
        end
        I_BUSY: begin
          if (mem_valid) begin
            i_data     <= mem_rdata;
            mem_enable <= 1'b0;
            i_ack      <= 1'b1;
            state      <= I_RESP;
          end
        end
        D_BUSY: begin
          if (mem_valid) begin
            // Write-backs return no data; keep the last read block visible.
            if (!mem_write) d_data <= mem_rdata;
            mem_enable <= 1'b0;
            d_ack      <= 1'b1;
            state      <= D_RESP;
          end
        end
        I_RESP, D_RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          mem_enable <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, multi-cycle corner
// sequences, and a randomized two-requester run against a requester-level model.
module tb_mem_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;

  // instance with round-robin arbitration
  logic         i_req0 = 0, d_req0 = 0, d_write0 = 0;
  logic [31:0]  i_addr0 = 0, d_addr0 = 0;
  logic [127:0] d_wdata0 = 0;
  logic         i_ack0, d_ack0, mem_enable0, mem_write0, busy0;
  logic [127:0] i_data0, d_data0, mem_wdata0;
  logic [31:0]  mem_addr0;
  logic         mv0 = 0, spur_valid = 0;
  logic [127:0] rd0 = 0, spur_data = 0;
  logic         mem_valid0;
  logic [127:0] mem_rdata0;
  assign mem_valid0 = mv0 | spur_valid;
  assign mem_rdata0 = spur_valid ? spur_data : rd0;

  // instance with data-side priority
  logic         i_req1 = 0, d_req1 = 0, d_write1 = 0;
  logic [31:0]  i_addr1 = 0, d_addr1 = 0;
  logic [127:0] d_wdata1 = 0;
  logic         i_ack1, d_ack1, mem_enable1, mem_write1, busy1;
  logic [127:0] i_data1, d_data1, mem_wdata1;
  logic [31:0]  mem_addr1;
  logic         mv1 = 0;
  logic [127:0] rd1 = 0;

  mem_arbiter #(.DATA_PRIORITY(0)) dut0 (
    .clock(clock), .reset(reset),
    .i_req(i_req0), .i_addr(i_addr0), .i_ack(i_ack0), .i_data(i_data0),
    .d_req(d_req0), .d_write(d_write0), .d_addr(d_addr0), .d_wdata(d_wdata0),
    .d_ack(d_ack0), .d_data(d_data0),
    .mem_enable(mem_enable0), .mem_write(mem_write0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0), .mem_valid(mem_valid0),
    .busy(busy0)
  );

  mem_arbiter #(.DATA_PRIORITY(1)) dut1 (
    .clock(clock), .reset(reset),
    .i_req(i_req1), .i_addr(i_addr1), .i_ack(i_ack1), .i_data(i_data1),
    .d_req(d_req1), .d_write(d_write1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_ack(d_ack1), .d_data(d_data1),
    .mem_enable(mem_enable1), .mem_write(mem_write1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(rd1), .mem_valid(mv1),
    .busy(busy1)
  );

  initial forever #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] pat(input logic [31:0] a);
    return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h1357_9BDF};
  endfunction

  // ---------------- memory responder for dut0 ----------------
  logic [127:0] mem0 [logic [31:0]];
  int           lat0 = 2;
  bit           rand_lat = 0;
  int           cnt0 = 0, last_en0 = 0;
  logic [31:0]  last_addr0 = 0;
  logic         last_wr0 = 0;
  logic [127:0] last_wd0 = 0;
  bit           grant_q0 [$];

  initial forever begin
    @(negedge clock);
    if (mem_enable0 && !mv0) begin
      if (cnt0 == 0) begin
        last_addr0 = mem_addr0;
        last_wr0   = mem_write0;
        last_wd0   = mem_wdata0;
        grant_q0.push_back(mem_addr0[31]);
        if (rand_lat) lat0 = $urandom_range(1, 6);
        chk("mem_addr_aligned", {124'd0, mem_addr0[3:0]}, 128'd0);
      end else begin
        chk("mem_stable", {mem_write0, mem_addr0, mem_wdata0},
            {last_wr0, last_addr0, last_wd0});
      end
      cnt0++;
      if (cnt0 >= lat0) begin
        mv0      = 1'b1;
        last_en0 = cnt0;
        if (last_wr0) begin
          mem0[last_addr0] = last_wd0;
          rd0 = {$urandom, $urandom, $urandom, $urandom};
        end else begin
          rd0 = mem0.exists(last_addr0) ? mem0[last_addr0] : pat(last_addr0);
        end
      end
    end else begin
      mv0  = 1'b0;
      cnt0 = 0;
    end
  end

  // ---------------- memory responder for dut1 (fixed latency 2) ----------------
  int cnt1 = 0;
  bit grant_q1 [$];
  initial forever begin
    @(negedge clock);
    if (mem_enable1 && !mv1) begin
      if (cnt1 == 0) grant_q1.push_back(mem_addr1[31]);
      cnt1++;
      if (cnt1 >= 2) begin
        mv1 = 1'b1;
        rd1 = pat(mem_addr1);
      end
    end else begin
      mv1  = 1'b0;
      cnt1 = 0;
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    i_req0 = 0; d_req0 = 0; i_req1 = 0; d_req1 = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic txn0(input string nm, input bit is_d, input bit wr,
                      input logic [31:0] a, input logic [127:0] wd, input int lat,
                      input logic [31:0] e_addr, input logic [127:0] e_data);
    bit got, other;
    got = 0; other = 0;
    lat0 = lat;
    if (is_d) begin
      d_addr0 = a; d_write0 = wr; d_wdata0 = wd; d_req0 = 1;
    end else begin
      i_addr0 = a; i_req0 = 1;
    end
    for (int k = 0; k < 60; k++) begin
      @(negedge clock);
      if (is_d ? i_ack0 : d_ack0) other = 1;
      if (is_d ? d_ack0 : i_ack0) begin
        got = 1;
        break;
      end
    end
    chk({nm, "_ack"}, got, 1);
    chk({nm, "_other_ack"}, other, 0);
    chk({nm, "_mem_addr"}, last_addr0, e_addr);
    chk({nm, "_mem_write"}, last_wr0, is_d & wr);
    chk({nm, "_en_cycles"}, last_en0, lat);
    if (is_d && wr) chk({nm, "_mem_wdata"}, last_wd0, wd);
    chk({nm, "_data"}, is_d ? d_data0 : i_data0, e_data);
    chk({nm, "_enable_dropped"}, mem_enable0, 0);
    @(negedge clock);
    chk({nm, "_ack_pulse"}, is_d ? d_ack0 : i_ack0, 0);
    chk({nm, "_idle_gap"}, busy0, 0);
    i_req0 = 0;
    d_req0 = 0;
  endtask

  typedef struct {
    string        nm;
    bit           is_d;
    bit           wr;
    logic [31:0]  addr;
    logic [127:0] wdata;
    int           lat;
    logic [31:0]  exp_addr;
    logic [127:0] exp_data;
  } vec_t;

  vec_t vecs [7];

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] wp;
    logic [127:0] h_i, h_d, h_wd;
    logic [31:0]  h_a;
    logic         h_w;
    bit           seen;
    int           n;
    logic [7:0]   ord;
    logic [127:0] exp_i_last, exp_d_last;
    logic [127:0] gd [logic [31:0]];

    wp = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
    vecs[0] = '{"v_i_1234",   0, 0, 32'h0000_1234, 0,  3, 32'h0000_1230, pat(32'h0000_1230)};
    vecs[1] = '{"v_d_rd_40",  1, 0, 32'h8000_0040, 0,  2, 32'h8000_0040, pat(32'h8000_0040)};
    vecs[2] = '{"v_d_wr_4c",  1, 1, 32'h8000_004C, wp, 2, 32'h8000_0040, pat(32'h8000_0040)};
    vecs[3] = '{"v_d_rd_48",  1, 0, 32'h8000_0048, 0,  1, 32'h8000_0040, wp};
    vecs[4] = '{"v_i_0fff",   0, 0, 32'h0000_0FFF, 0,  1, 32'h0000_0FF0, pat(32'h0000_0FF0)};
    vecs[5] = '{"v_d_ffff",   1, 0, 32'hFFFF_FFFF, 0,  6, 32'hFFFF_FFF0, pat(32'hFFFF_FFF0)};
    vecs[6] = '{"v_i_7fff",   0, 0, 32'h7FFF_FFF1, 0,  4, 32'h7FFF_FFF0, pat(32'h7FFF_FFF0)};

    #2 reset = 1'b1;
    #1;
    chk("rst_ctrl0", {i_ack0, d_ack0, mem_enable0, mem_write0, busy0}, 0);
    chk("rst_mem_addr0", mem_addr0, 0);
    chk("rst_mem_wdata0", mem_wdata0, 0);
    chk("rst_i_data0", i_data0, 0);
    chk("rst_d_data0", d_data0, 0);
    chk("rst_ctrl1", {i_ack1, d_ack1, mem_enable1, mem_write1, busy1, mem_wdata1}, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    for (int v = 0; v < 7; v++)
      txn0(vecs[v].nm, vecs[v].is_d, vecs[v].wr, vecs[v].addr, vecs[v].wdata,
           vecs[v].lat, vecs[v].exp_addr, vecs[v].exp_data);

    // Spurious mem_valid while idle must be ignored.
    h_i = i_data0; h_d = d_data0; h_a = mem_addr0; h_w = mem_write0; h_wd = mem_wdata0;
    @(negedge clock);
    spur_data  = {$urandom, $urandom, $urandom, $urandom};
    spur_valid = 1'b1;
    @(negedge clock);
    spur_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      if (i_ack0 || d_ack0 || busy0 || mem_enable0) seen = 1;
      @(negedge clock);
    end
    chk("spur_no_activity", seen, 0);
    chk("spur_i_data", i_data0, h_i);
    chk("spur_d_data", d_data0, h_d);
    chk("spur_mem_regs", {h_w, h_a, h_wd} ^ {mem_write0, mem_addr0, mem_wdata0}, 0);

    // Reset in the middle of a data write-back.
    lat0 = 10;
    d_addr0 = 32'h8000_0100; d_write0 = 1; d_wdata0 = wp; d_req0 = 1;
    repeat (3) @(negedge clock);
    chk("rstmid_pre_busy", {busy0, mem_enable0}, 2'b11);
    reset = 1'b1;
    #1;
    chk("rstmid_enable_async", {mem_enable0, busy0, d_ack0}, 0);
    @(negedge clock);
    reset  = 1'b0;
    d_req0 = 0;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (d_ack0 || mem_enable0) seen = 1;
    end
    chk("rstmid_no_ack", seen, 0);
    chk("rstmid_no_write", mem0.exists(32'h8000_0100), 0);
    txn0("rstmid_next_i", 0, 0, 32'h0000_2004, 0, 2, 32'h0000_2000, pat(32'h0000_2000));

    // Both requests held continuously, round-robin: I, D, I, D.
    do_reset();
    grant_q0.delete();
    lat0 = 2;
    i_addr0 = 32'h0000_0300; i_req0 = 1;
    d_addr0 = 32'h8000_0300; d_write0 = 0; d_req0 = 1;
    n = 0; ord = 0;
    for (int k = 0; k < 200 && n < 4; k++) begin
      @(negedge clock);
      if (i_ack0 || d_ack0) begin
        ord = {ord[6:0], d_ack0};
        n++;
        if (i_ack0) i_addr0 = i_addr0 + 16;
        else        d_addr0 = d_addr0 + 16;
        @(negedge clock);
        chk("rr_idle_gap", busy0, 0);
        if (n == 4) begin
          i_req0 = 0;
          d_req0 = 0;
        end
      end
    end
    chk("rr_ack_count", n, 4);
    chk("rr_ack_order", ord[3:0], 4'b0101);
    ord = 0;
    foreach (grant_q0[q]) ord = {ord[6:0], grant_q0[q]};
    chk("rr_grant_count", grant_q0.size(), 4);
    chk("rr_grant_order", ord[3:0], 4'b0101);

    // Data priority: D twice while held, I only after d_req drops.
    grant_q1.delete();
    i_addr1 = 32'h0000_0100; i_req1 = 1;
    d_addr1 = 32'h8000_0200; d_write1 = 0; d_req1 = 1;
    n = 0; ord = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (d_ack1) begin
        ord = {ord[6:0], 1'b1};
        n++;
        if (n == 2) d_req1 = 0;
        else        d_addr1 = d_addr1 + 16;
      end
      if (i_ack1) begin
        ord = {ord[6:0], 1'b0};
        n++;
        i_req1 = 0;
        break;
      end
    end
    chk("pri_ack_count", n, 3);
    chk("pri_ack_order", ord[2:0], 3'b110);
    ord = 0;
    foreach (grant_q1[q]) ord = {ord[6:0], grant_q1[q]};
    chk("pri_grant_order", {grant_q1.size(), ord[2:0]}, {32'd3, 3'b110});
    chk("pri_d_data", d_data1, pat(32'h8000_0210));
    chk("pri_i_data", i_data1, pat(32'h0000_0100));
    chk("pri_mem_write", mem_write1, 0);

    // Randomized concurrent traffic against a requester-level model.
    do_reset();
    mem0.delete();
    rand_lat   = 1;
    exp_i_last = 0;
    exp_d_last = 0;
    fork
      begin
        logic [31:0] a;
        bit got;
        for (int t = 0; t < 25; t++) begin
          repeat ($urandom_range(0, 3)) @(negedge clock);
          chk("rnd_i_hold", i_data0, exp_i_last);
          a = $urandom & 32'h7FFF_FFFF;
          i_addr0 = a; i_req0 = 1;
          got = 0;
          for (int k = 0; k < 400; k++) begin
            @(negedge clock);
            if (i_ack0) begin got = 1; break; end
          end
          chk("rnd_i_ack", got, 1);
          exp_i_last = pat({a[31:4], 4'b0000});
          chk("rnd_i_data", i_data0, exp_i_last);
          @(negedge clock);
          chk("rnd_i_pulse", i_ack0, 0);
          i_req0 = 0;
        end
      end
      begin
        logic [31:0]  a, blk;
        logic [127:0] wd;
        bit got, wr;
        for (int t = 0; t < 25; t++) begin
          repeat ($urandom_range(0, 3)) @(negedge clock);
          chk("rnd_d_hold", d_data0, exp_d_last);
          blk = 32'h8000_0000 | (32'($urandom_range(0, 7)) << 4);
          a   = blk | 32'($urandom_range(0, 15));
          wr  = 1'($urandom_range(0, 1));
          wd  = {$urandom, $urandom, $urandom, $urandom};
          d_addr0 = a; d_write0 = wr; d_wdata0 = wd; d_req0 = 1;
          got = 0;
          for (int k = 0; k < 400; k++) begin
            @(negedge clock);
            if (d_ack0) begin got = 1; break; end
          end
          chk("rnd_d_ack", got, 1);
          if (wr) gd[blk] = wd;
          else    exp_d_last = gd.exists(blk) ? gd[blk] : pat(blk);
          chk("rnd_d_data", d_data0, exp_d_last);
          @(negedge clock);
          chk("rnd_d_pulse", d_ack0, 0);
          d_req0 = 0;
        end
      end
    join
    rand_lat = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter DATA_PRIORITY, default 0, meaning 0 = round-robin between requesters and 1 = data side always wins ties.
REQ-002 The module SHALL have one clock; reset is asynchronous and active-high.
REQ-003 The module SHALL have port clock, input, 1 bit: system clock, all state on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous active-high reset.
REQ-005 The module SHALL have port i_req, input, 1 bit: instruction-side block read request, level, held until i_ack.
REQ-006 The module SHALL have port i_addr, input, 32 bits: instruction-side byte address.
REQ-007 The module SHALL have port i_ack, output, 1 bit: one-cycle pulse, i_data valid.
REQ-008 The module SHALL have port i_data, output, 128 bits: returned instruction block.
REQ-009 The module SHALL have port d_req, input, 1 bit: data-side request, level, held until d_ack.
REQ-010 The module SHALL have port d_write, input, 1 bit: 1 = block write-back, 0 = block read.
REQ-011 The module SHALL have port d_addr, input, 32 bits: data-side byte address.
REQ-012 The module SHALL have port d_wdata, input, 128 bits: write-back block.
REQ-013 The module SHALL have port d_ack, output, 1 bit: one-cycle pulse, transaction complete.
REQ-014 The module SHALL have port d_data, output, 128 bits: returned data block (reads only).
REQ-015 The module SHALL have port mem_enable, output, 1 bit: memory access request.
REQ-016 The module SHALL have port mem_write, output, 1 bit: 1 = write access.
REQ-017 The module SHALL have port mem_addr, output, 32 bits: block-aligned address.
REQ-018 The module SHALL have port mem_wdata, output, 128 bits: write block.
REQ-019 The module SHALL have port mem_rdata, input, 128 bits: read block.
REQ-020 The module SHALL have port mem_valid, input, 1 bit: memory completed current access.
REQ-021 The module SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-022 FSM states SHALL be IDLE, I_BUSY, D_BUSY, I_RESP, D_RESP; all outputs registered.
REQ-023 IDLE: i_req only -> I_BUSY; d_req only -> D_BUSY; neither -> stay in IDLE.
REQ-024 IDLE with both requests and DATA_PRIORITY=0: grant the side not granted last (last_grant register); DATA_PRIORITY=1: grant D.
REQ-025 On grant: latch {addr[31:4],4'b0} into mem_addr, latch d_write and d_wdata (D only; I forces mem_write=0), update last_grant, set mem_enable=1 from the next cycle.
REQ-026 Latency: request sampled in IDLE at edge n -> mem_enable high in cycle n+1.
REQ-027 x_BUSY: mem_enable, mem_addr, mem_write, mem_wdata SHALL remain stable until the cycle mem_valid is sampled high.
REQ-028 x_BUSY with mem_valid=1: capture mem_rdata into i_data (I) or d_data (D read only; unchanged on write), drop mem_enable, go to x_RESP.
REQ-029 x_RESP: assert i_ack or d_ack for exactly one cycle, then go to IDLE.
REQ-030 The requester SHALL drop its req at the edge ending its ack cycle; the arbiter re-samples requests in IDLE only, with one IDLE cycle between transactions.
REQ-031 mem_valid sampled while in IDLE or x_RESP SHALL be ignored.
REQ-032 i_data and d_data SHALL hold their last captured value until the next completing read on the same side.
REQ-033 A request arriving during another side's transaction SHALL wait; there is no pre-emption and no request is dropped.

Reset
REQ-034 reset high SHALL asynchronously force state IDLE; i_ack, d_ack, mem_enable, mem_write, and busy to 0; mem_addr, mem_wdata, i_data, and d_data to 0; and last_grant to D, so I wins the first tie.
REQ-035 Reset during x_BUSY SHALL abandon the transaction with no ack, and mem_enable low immediately.

Verification
REQ-036 i_req, i_addr=0x0000_1234, memory valid after 3 cycles -> mem_addr=0x0000_1230, mem_write=0, mem_enable for 3 cycles, i_ack one cycle later with i_data=mem_rdata.
REQ-037 d_req, d_write=1, d_addr=0x8000_004C, d_wdata=pattern -> mem_write=1, mem_addr=0x8000_0040, mem_wdata=pattern, d_ack, d_data unchanged.
REQ-038 Both requests held continuously with DATA_PRIORITY=0 -> grant order I, D, I, D, with one IDLE cycle between transactions.
REQ-039 Same test with DATA_PRIORITY=1 -> D served first, I served after d_req drops.
REQ-040 Reset asserted mid-D_BUSY -> mem_enable=0 asynchronously, no d_ack, next i_req served normally.
REQ-041 Spurious mem_valid pulse in IDLE -> no ack, outputs unchanged.
